// File: rtl/logo_command_assembler.sv
// logo_command_assembler: gathers PS/2 scan bytes into 32-bit command words behind a 2-deep FIFO
module logo_command_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter logic [7:0]  BREAK_CODE     = 8'hF0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_pressed,
  input  logic [7:0]  key_data,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [31:0] cmd_data,
  output logic [1:0]  byte_index,
  output logic        overflow,
  output logic        timeout_pulse
);
  typedef enum logic [1:0] {IDLE, COLLECT, BRK} state_t;
  localparam logic [31:0] TMAX = 32'(TIMEOUT_CYCLES - 1);
  state_t      state_q, state_d;
  logic        prev_q, prev_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] word_q, word_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]  fill_q, fill_d, fill_pop;
  logic        ovf_q, ovf_d;
  logic        accept, push, pop, push_ok;
  logic [31:0] push_word;
  assign accept     = key_pressed & ~prev_q;
  assign push_word  = {word_q, key_data};
  assign cmd_valid  = fill_q != 2'd0;
  assign cmd_data   = cmd_valid ? e0_q : '0;
  assign byte_index = idx_q;
  assign overflow   = ovf_q;
  // byte collection, release filtering and idle timeout
  always_comb begin
    prev_d        = key_pressed;
    state_d       = state_q;
    idx_d         = idx_q;
    word_d        = word_q;
    cnt_d         = (state_q == IDLE) ? '0 : cnt_q + 32'd1;
    push          = 1'b0;
    timeout_pulse = 1'b0;
    if (accept) begin
      cnt_d = '0;
      if (state_q == BRK) state_d = (idx_q == 2'd0) ? IDLE : COLLECT;
      else if (key_data == BREAK_CODE) state_d = BRK;
      else if (idx_q == 2'd3) begin
        push    = 1'b1;
        idx_d   = 2'd0;
        state_d = IDLE;
      end else begin
        word_d  = idx_q == 2'd0 ? {key_data, word_q[15:0]} :
                  idx_q == 2'd1 ? {word_q[23:16], key_data, word_q[7:0]} :
                                  {word_q[23:8], key_data};
        idx_d   = idx_q + 2'd1;
        state_d = COLLECT;
      end
    end else if (state_q != IDLE && cnt_q == TMAX) begin
      timeout_pulse = 1'b1;
      idx_d         = 2'd0;
      cnt_d         = '0;
      state_d       = IDLE;
    end
  end
  // two-entry command buffer; a pop frees room for a same-cycle push
  always_comb begin
    pop      = cmd_valid & cmd_ready;
    push_ok  = push & (fill_q != 2'd2 | pop);
    fill_pop = fill_q - {1'b0, pop};
    e0_d     = (push_ok && fill_pop == 2'd0) ? push_word : pop ? e1_q : e0_q;
    e1_d     = (push_ok && fill_pop != 2'd0) ? push_word : e1_q;
    fill_d   = fill_pop + {1'b0, push_ok};
    ovf_d    = ovf_q | (push & ~push_ok);
  end
  // state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q  <= 1'b1;
      idx_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      e0_q    <= '0;
      e1_q    <= '0;
      fill_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      fill_q  <= fill_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
